// File: rtl/fifo_fill_drain_ctrl_pkg.sv
// rtl/fifo_fill_drain_ctrl_pkg.sv - shared state encoding and default sizes for the fill/drain controller
package fifo_fill_drain_ctrl_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FILL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // One extra bit so a counter can hold DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_fill_drain_ctrl_rd_checker.sv
// rtl/fifo_fill_drain_ctrl_rd_checker.sv - read-data checker: tracks returned words and flags mismatches
module fifo_rd_checker
    import fifo_fill_drain_ctrl_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CW     = cnt_width(DEFAULT_DEPTH),
    parameter int SEED   = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              clr_cnt,
    input  logic              clr_err,
    input  logic              rd_req,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              rd_vld,
    output logic [CW-1:0]     chk_cnt,
    output logic              err
);

    logic [DATA_W-1:0] exp_data;

    assign exp_data = DATA_W'(SEED) + DATA_W'(chk_cnt);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_vld  <= 1'b0;
            chk_cnt <= '0;
            err     <= 1'b0;
        end else begin
            rd_vld <= rd_req;
            if (clr_cnt) begin
                chk_cnt <= '0;
            end else if (rd_vld) begin
                chk_cnt <= chk_cnt + CW'(1);
            end
            // Sticky until a fresh burst is launched from idle.
            if (clr_err) begin
                err <= 1'b0;
            end else if (rd_vld && (fifo_rd_data != exp_data)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_fill_drain_ctrl.sv
// rtl/fifo_fill_drain_ctrl.sv - burst fill/drain controller: clears, fills, drains and checks an external FIFO
module fifo_fill_drain_ctrl
    import fifo_fill_drain_ctrl_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int FILL_LEN = 256,
    parameter int SEED     = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_sclr,
    output logic              wr_req,
    output logic              rd_req,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       burst_cnt
);

    localparam int            CW  = cnt_width(DEPTH);
    localparam logic [CW-1:0] LEN = CW'(FILL_LEN);

    state_t        state;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] chk_cnt;
    logic          stop_pend;
    logic          from_idle;
    logic          rd_vld;
    logic          err_q;
    logic [15:0]   burst_q;
    logic          run;
    logic          wr_go;
    logic          rd_go;

    // Outputs are masked while reset is asserted so nothing leaks in the reset cycle.
    assign run   = !sys_rst;
    assign wr_go = run && (state == ST_FILL) && !fifo_full && (wr_cnt < LEN);
    assign rd_go = run && (state == ST_DRAIN) && !fifo_empty && (rd_cnt < wr_cnt);

    assign wr_req    = wr_go;
    assign rd_req    = rd_go;
    assign wr_data   = (run && state == ST_FILL) ? DATA_W'(SEED) + DATA_W'(wr_cnt) : '0;
    assign fifo_sclr = run && (state == ST_CLR);
    assign busy      = run && (state != ST_IDLE);
    assign done      = run && (state == ST_DONE);
    assign err       = run && err_q;
    assign burst_cnt = run ? burst_q : '0;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            stop_pend <= 1'b0;
            from_idle <= 1'b0;
            burst_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stop_pend <= 1'b0;
                    if (start && !stop) begin
                        state     <= ST_CLR;
                        from_idle <= 1'b1;
                    end
                end
                ST_CLR: begin
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    state <= ST_FILL;
                end
                ST_FILL: begin
                    if (wr_go) begin
                        wr_cnt <= wr_cnt + CW'(1);
                    end
                    // A write issued alongside stop still counts and will be drained.
                    if (stop) begin
                        stop_pend <= 1'b1;
                        state     <= ST_DRAIN;
                    end else if (wr_go && (wr_cnt == LEN - CW'(1))) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rd_go) begin
                        rd_cnt <= rd_cnt + CW'(1);
                    end
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if ((chk_cnt == wr_cnt) && !rd_vld) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    burst_q <= burst_q + 16'd1;
                    if (loop_en && !stop_pend && !stop) begin
                        state     <= ST_CLR;
                        from_idle <= 1'b0;
                    end else begin
                        state     <= ST_IDLE;
                        stop_pend <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fifo_rd_checker #(
        .DATA_W (DATA_W),
        .CW     (CW),
        .SEED   (SEED)
    ) u_rd_checker (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .clr_cnt      (state == ST_CLR),
        .clr_err      ((state == ST_CLR) && from_idle),
        .rd_req       (rd_go),
        .fifo_rd_data (fifo_rd_data),
        .rd_vld       (rd_vld),
        .chk_cnt      (chk_cnt),
        .err          (err_q)
    );

endmodule
